mem_store_buffer: RTL and testbench

Write-side companion to the MEM-stage load path. It accepts store operations (st.b / st.h / st.w) from the pipeline and performs lane steering and byte-enable generation. It holds stores in a small FIFO and issues them to the data SRAM over a req/addr_ok/data_ok handshake, with one transaction outstanding at a time. Misaligned stores are reported as ALE instead of being written.

---
 rtl/mem_store_buffer.sv | 154 +++++++++++++++
 tb/tb_mem_store_buffer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: lane steering, byte enables, small FIFO and a single-outstanding SRAM write issuer.
// Optional misaligned-store (ALE) reporting is enabled by defining MEM_STORE_ALE_EN.
module mem_store_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [3:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        ale_valid,
  output logic [31:0] ale_badv,
  output logic        sb_empty,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             is_b, is_h, is_w;
  logic             misaligned;
  logic             full;
  logic             accept;
  logic             push;
  logic             pop;

  assign is_b   = (st_op == 4'd0);
  assign is_h   = (st_op == 4'd1);
  assign is_w   = (st_op == 4'd2);
  assign full   = (count == CNT_W'(DEPTH));
  assign st_ready = ~full & ~flush;
  assign accept = st_valid & st_ready;

`ifdef MEM_STORE_ALE_EN
  assign misaligned = (is_h & st_addr[0]) | (is_w & (st_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Invalid ops and misaligned stores are consumed without entering the FIFO
  assign push = accept & (is_b | is_h | is_w) & ~misaligned;
  assign pop  = (state == S_REQ) & data_sram_addr_ok;

  // Lane steering and byte-enable generation at acceptance
  always_comb begin
    new_entry.addr  = st_addr[31:2];
    new_entry.wstrb = 4'b0000;
    new_entry.wdata = st_data;
    if (is_b) begin
      new_entry.wstrb = 4'b0001 << st_addr[1:0];
      new_entry.wdata = {4{st_data[7:0]}};
    end else if (is_h) begin
      new_entry.wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
      new_entry.wdata = {2{st_data[15:0]}};
    end else if (is_w) begin
      new_entry.wstrb = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Flush keeps only the head currently presented in REQ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      if (state == S_REQ) begin
        wr_ptr <= rd_ptr + PTR_W'(1);
        rd_ptr <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count  <= pop ? CNT_W'(0) : CNT_W'(1);
      end else begin
        wr_ptr <= rd_ptr;
        count  <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Issue FSM: one SRAM write outstanding at a time
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if ((count != '0) && !flush) state_nxt = S_REQ;
      S_REQ:   if (data_sram_addr_ok)       state_nxt = S_WAIT;
      S_WAIT:  if (data_sram_data_ok)       state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef MEM_STORE_ALE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ale_valid <= 1'b0;
      ale_badv  <= '0;
    end else begin
      ale_valid <= accept & misaligned;
      if (accept & misaligned) ale_badv <= st_addr;
    end
  end
`else
  assign ale_valid = 1'b0;
  assign ale_badv  = '0;
`endif

  assign head            = mem[rd_ptr];
  assign data_sram_req   = (state == S_REQ);
  assign data_sram_wr    = 1'b1;
  assign data_sram_wstrb = data_sram_req ? head.wstrb : 4'b0000;
  assign data_sram_addr  = data_sram_req ? {head.addr, 2'b00} : 32'h0;
  assign data_sram_wdata = data_sram_req ? head.wdata : 32'h0;
  assign sb_empty        = (count == '0) & (state == S_IDLE);

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed scenarios plus randomized stores against a queue model.
// Honours MEM_STORE_ALE_EN the same way the design does.
module tb_mem_store_buffer;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        st_valid;
  logic        st_ready;
  logic [3:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ale_valid;
  logic [31:0] ale_badv;
  logic        sb_empty;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_op             (st_op),
    .st_addr           (st_addr),
    .st_data           (st_data),
    .ale_valid         (ale_valid),
    .ale_badv          (ale_badv),
    .sb_empty          (sb_empty),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Access size in bytes; 0 marks an op that is dropped
  function automatic int size_of(input logic [3:0] op);
    case (op)
      4'd0:    return 1;
      4'd1:    return 2;
      4'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_mis(input logic [3:0] op, input logic [31:0] a);
    int sz = size_of(op);
    bit m  = (sz != 0) && ((int'(a[1:0]) % sz) != 0);
`ifndef MEM_STORE_ALE_EN
    m = 1'b0;
`endif
    return m;
  endfunction

  // Naturally aligned container of the access; bytes of data repeat across every lane
  function automatic wr_t model_entry(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    int  sz   = size_of(op);
    int  base = int'(a[1:0]) - (int'(a[1:0]) % sz);
    e.addr = {a[31:2], 2'b00};
    e.strb = 4'b0000;
    for (int lane = 0; lane < 4; lane++) begin
      if (lane >= base && lane < base + sz) e.strb[lane] = 1'b1;
      e.data[lane*8 +: 8] = d[(lane % sz)*8 +: 8];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  // Services requests until the model queue is empty and the buffer reports empty
  task automatic drain(input bit in_wait, input string tag);
    bit  waiting = in_wait;
    bit  done    = 1'b0;
    wr_t e;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      if (waiting) begin
        data_sram_data_ok = 1'b1;
        waiting = 1'b0;
      end else if (data_sram_req) begin
        data_sram_addr_ok = 1'b1;
        waiting = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_unexpected_req: got addr=%h wstrb=%b, required no request", tag, data_sram_addr, data_sram_wstrb);
        end else begin
          e = exp_q.pop_front();
          if ({data_sram_addr, data_sram_wstrb, data_sram_wdata} !== {e.addr, e.strb, e.data}) begin
            errors++;
            $display("FAIL %s_write: got addr=%h wstrb=%b wdata=%h, required addr=%h wstrb=%b wdata=%h",
                     tag, data_sram_addr, data_sram_wstrb, data_sram_wdata, e.addr, e.strb, e.data);
          end
        end
      end else if (exp_q.size() == 0 && sb_empty) begin
        done = 1'b1;
      end
    end
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d writes left, sb_empty=%b, required 0 left and sb_empty=1", tag, exp_q.size(), sb_empty);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; st_valid = 1'b0; st_op = 4'd0; st_addr = '0; st_data = '0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    #3;
    checks++;
    if ({data_sram_req, st_ready, sb_empty, data_sram_wr, ale_valid} !== 5'b01110) begin
      errors++;
      $display("FAIL reset_flags: got req=%b rdy=%b empty=%b wr=%b ale=%b, required 0 1 1 1 0",
               data_sram_req, st_ready, sb_empty, data_sram_wr, ale_valid);
    end
    checks++;
    if ({data_sram_wstrb, data_sram_addr, data_sram_wdata, ale_badv} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got wstrb=%b addr=%h wdata=%h badv=%h, required all zero",
               data_sram_wstrb, data_sram_addr, data_sram_wdata, ale_badv);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic test_byte_store();
    tick(); offer(4'd0, 32'h1003, 32'hAB);
    tick(); st_valid = 1'b0; #2;
    checks++;
    if (data_sram_req !== 1'b0 || sb_empty !== 1'b0) begin
      errors++; $display("FAIL byte_n1: got req=%b empty=%b, required req=0 empty=0", data_sram_req, sb_empty);
    end
    tick(); data_sram_addr_ok = 1'b1; #2;
    checks++;
    if ({data_sram_req, data_sram_wstrb, data_sram_addr, data_sram_wdata} !== {1'b1, 4'b1000, 32'h1000, 32'hABABABAB}) begin
      errors++;
      $display("FAIL byte_req: got req=%b wstrb=%b addr=%h wdata=%h, required 1 1000 00001000 abababab",
               data_sram_req, data_sram_wstrb, data_sram_addr, data_sram_wdata);
    end
    tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; #2;
    checks++;
    if (data_sram_req !== 1'b0) begin
      errors++; $display("FAIL byte_wait_req: got %b, required 0", data_sram_req);
    end
    tick(); data_sram_data_ok = 1'b0; #2;
    checks++;
    if (sb_empty !== 1'b1) begin
      errors++; $display("FAIL byte_empty: got %b, required 1", sb_empty);
    end
  endtask

  task automatic test_back_to_back();
    tick(); offer(4'd1, 32'h2002, 32'h1234);
    tick(); offer(4'd2, 32'h3000, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      tick(); st_valid = 1'b0; data_sram_addr_ok = (k == 3); #2;
      checks++;
      if ({data_sram_req, data_sram_wstrb, data_sram_addr, data_sram_wdata} !== {1'b1, 4'b1100, 32'h2000, 32'h12341234}) begin
        errors++;
        $display("FAIL b2b_hold cyc%0d: got req=%b wstrb=%b addr=%h wdata=%h, required 1 1100 00002000 12341234",
                 k, data_sram_req, data_sram_wstrb, data_sram_addr, data_sram_wdata);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = (k == 2); #2;
      checks++;
      if (data_sram_req !== 1'b0) begin
        errors++; $display("FAIL b2b_gap cyc%0d: got req=%b, required 0", k, data_sram_req);
      end
    end
    data_sram_data_ok = 1'b0;
    exp_q.push_back('{addr: 32'h3000, strb: 4'b1111, data: 32'hDEADBEEF});
    drain(1'b0, "b2b");
  endtask

  task automatic test_misaligned();
    tick(); offer(4'd2, 32'h4001, 32'h55);
    tick(); st_valid = 1'b0; #2;
`ifdef MEM_STORE_ALE_EN
    checks++;
    if ({ale_valid, ale_badv, sb_empty} !== {1'b1, 32'h4001, 1'b1}) begin
      errors++; $display("FAIL ale_pulse: got ale=%b badv=%h empty=%b, required 1 00004001 1", ale_valid, ale_badv, sb_empty);
    end
    tick(); #2;
    checks++;
    if ({ale_valid, data_sram_req, sb_empty} !== 3'b001) begin
      errors++; $display("FAIL ale_after: got ale=%b req=%b empty=%b, required 0 0 1", ale_valid, data_sram_req, sb_empty);
    end
`else
    checks++;
    if (ale_valid !== 1'b0) begin
      errors++; $display("FAIL noale_valid: got %b, required 0", ale_valid);
    end
    exp_q.push_back('{addr: 32'h4000, strb: 4'b1111, data: 32'h55});
`endif
    drain(1'b0, "misaligned");
  endtask

  task automatic test_full();
    tick(); offer(4'd0, 32'h5000, 32'h11); #2;
    checks++;
    if (st_ready !== 1'b1) begin errors++; $display("FAIL full_rdy0: got %b, required 1", st_ready); end
    tick(); offer(4'd0, 32'h5001, 32'h22);
    tick(); offer(4'd2, 32'h5004, 32'h33445566); #2;
    checks++;
    if (st_ready !== 1'b0 || data_sram_req !== 1'b1) begin
      errors++; $display("FAIL full_stall: got rdy=%b req=%b, required rdy=0 req=1", st_ready, data_sram_req);
    end
    tick(); data_sram_addr_ok = 1'b1; #2;
    checks++;
    if (st_ready !== 1'b0 || {data_sram_addr, data_sram_wstrb} !== {32'h5000, 4'b0001}) begin
      errors++; $display("FAIL full_pop: got rdy=%b addr=%h wstrb=%b, required 0 00005000 0001", st_ready, data_sram_addr, data_sram_wstrb);
    end
    tick(); data_sram_addr_ok = 1'b0; #2;
    checks++;
    if (st_ready !== 1'b1) begin errors++; $display("FAIL full_resume: got %b, required 1", st_ready); end
    tick(); st_valid = 1'b0;
    exp_q.push_back('{addr: 32'h5000, strb: 4'b0010, data: 32'h22222222});
    exp_q.push_back('{addr: 32'h5004, strb: 4'b1111, data: 32'h33445566});
    drain(1'b1, "full");
  endtask

  task automatic test_flush();
    tick(); offer(4'd2, 32'h6000, 32'h01010101);
    tick(); offer(4'd2, 32'h6004, 32'h02020202);
    tick(); offer(4'd2, 32'h6001, 32'h99); flush = 1'b1; #2;
    checks++;
    if (st_ready !== 1'b0 || data_sram_req !== 1'b1) begin
      errors++; $display("FAIL flush_rdy: got rdy=%b req=%b, required rdy=0 req=1", st_ready, data_sram_req);
    end
    tick(); flush = 1'b0; st_valid = 1'b0; data_sram_addr_ok = 1'b1; #2;
    checks++;
    if ({ale_valid, data_sram_req, data_sram_addr, data_sram_wdata} !== {1'b0, 1'b1, 32'h6000, 32'h01010101}) begin
      errors++; $display("FAIL flush_head: got ale=%b req=%b addr=%h wdata=%h, required 0 1 00006000 01010101",
                         ale_valid, data_sram_req, data_sram_addr, data_sram_wdata);
    end
    drain(1'b1, "flush");
  endtask

  task automatic test_reset_in_wait();
    tick(); offer(4'd2, 32'h7000, 32'h77);
    tick(); offer(4'd2, 32'h7004, 32'h78);
    tick(); st_valid = 1'b0; data_sram_addr_ok = 1'b1;
    tick(); data_sram_addr_ok = 1'b0; #2;
    checks++;
    if (sb_empty !== 1'b0) begin errors++; $display("FAIL rst_pre_empty: got %b, required 0", sb_empty); end
    reset = 1'b1; #1;
    checks++;
    if ({data_sram_req, st_ready, sb_empty, data_sram_wstrb} !== {3'b011, 4'b0000}) begin
      errors++; $display("FAIL rst_async: got req=%b rdy=%b empty=%b wstrb=%b, required 0 1 1 0000",
                         data_sram_req, st_ready, sb_empty, data_sram_wstrb);
    end
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); data_sram_data_ok = (k == 0); #2;
      checks++;
      if (data_sram_req !== 1'b0 || sb_empty !== 1'b1) begin
        errors++; $display("FAIL rst_after cyc%0d: got req=%b empty=%b, required 0 1", k, data_sram_req, sb_empty);
      end
    end
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_random();
    bit          waiting = 1'b0;
    bit          exp_ale = 1'b0;
    bit          exp_ready;
    logic [31:0] exp_badv = '0;
    wr_t         e;
    for (int i = 0; i < 500; i++) begin
      tick();
      st_valid = ($urandom_range(0, 2) != 0);
      st_op    = ($urandom_range(0, 7) == 0) ? 4'd5 : 4'($urandom_range(0, 2));
      st_addr  = 32'h8000_0000 | ($urandom & 32'hFF);
      st_data  = $urandom;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      if (waiting) data_sram_data_ok = ($urandom_range(0, 2) == 0);
      else if (data_sram_req) data_sram_addr_ok = ($urandom_range(0, 1) == 1);
      #2;
      exp_ready = (exp_q.size() < DEPTH);
      checks++;
      if (st_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cyc%0d: got %b, required %b", i, st_ready, exp_ready);
      end
      checks++;
      if (ale_valid !== exp_ale || (exp_ale && ale_badv !== exp_badv)) begin
        errors++; $display("FAIL rand_ale cyc%0d: got ale=%b badv=%h, required ale=%b badv=%h", i, ale_valid, ale_badv, exp_ale, exp_badv);
      end
      if (waiting) begin
        checks++;
        if (data_sram_req !== 1'b0) begin
          errors++; $display("FAIL rand_outstanding cyc%0d: got req=%b, required 0", i, data_sram_req);
        end
      end
      if (data_sram_addr_ok) begin
        waiting = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected_req cyc%0d: got addr=%h, required no request", i, data_sram_addr);
        end else begin
          e = exp_q.pop_front();
          if ({data_sram_addr, data_sram_wstrb, data_sram_wdata} !== {e.addr, e.strb, e.data}) begin
            errors++;
            $display("FAIL rand_write cyc%0d: got addr=%h wstrb=%b wdata=%h, required addr=%h wstrb=%b wdata=%h",
                     i, data_sram_addr, data_sram_wstrb, data_sram_wdata, e.addr, e.strb, e.data);
          end
        end
      end
      if (data_sram_data_ok) waiting = 1'b0;
      exp_ale = 1'b0;
      if (st_valid && exp_ready && size_of(st_op) != 0) begin
        if (model_mis(st_op, st_addr)) begin
          exp_ale  = 1'b1;
          exp_badv = st_addr;
        end else begin
          exp_q.push_back(model_entry(st_op, st_addr, st_data));
        end
      end
    end
    tick(); st_valid = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = waiting;
    drain(1'b0, "rand");
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_back_to_back();
    test_misaligned();
    test_full();
    test_flush();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
